// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM blocks (capture side and generator side).
//   pwm_state_e    : capture FSM state encodings
//   meas_width()   : bit width of a measurement for a given duty resolution
//   timeout_count(): counter value at which a missing edge is declared
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,  // waiting for a clean low level
        ST_WAIT = 2'd1,  // low level seen, waiting for the first rise
        ST_HIGH = 2'd2,  // timing the high phase
        ST_LOW  = 2'd3   // timing the low phase
    } pwm_state_e;

    // One extra bit so a full 2^res period is representable.
    function automatic int unsigned meas_width(input int unsigned res);
        return res + 1;
    endfunction

    // All-ones value of a measurement; reaching it without an edge is a timeout.
    function automatic int unsigned timeout_count(input int unsigned res);
        return (32'd1 << (res + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_input_conditioner.sv
// Input conditioning for an asynchronous PWM line.
//   Synchronises i_pwm, optionally glitch-filters it (PWM_CAPTURE_FILTER_EN),
//   and produces single-cycle rise/fall strobes of the conditioned level.
// Ports:
//   i_clk    in   system clock
//   i_reset  in   synchronous active-high reset (all flops to 0)
//   i_pwm    in   asynchronous PWM input
//   o_level  out  conditioned level s
//   o_rise   out  s & ~s_prev
//   o_fall   out  ~s & s_prev
// Parameters:
//   SYNC_STAGES    synchroniser depth, must be >= 2
//   FILTER_CYCLES  stability length (present only with PWM_CAPTURE_FILTER_EN)
module pwm_input_conditioner #(
    parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_FILTER_EN
    ,
    parameter int FILTER_CYCLES = 3
`endif
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   level;
    logic                   prev_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    // The filtered level flips only after FILTER_CYCLES consecutive samples
    // that differ from it; any sample agreeing with it restarts the count.
    // Both edges see the same delay, so edge-to-edge timing is preserved.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else if (sync_lvl != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                filt_q <= sync_lvl;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_lvl;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign o_level = level;
    assign o_rise  = level & ~prev_q;
    assign o_fall  = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures high time and rise-to-rise period of an external
// PWM signal, one result per period, with a timeout for a stuck input.
// Optional glitch filter: define PWM_CAPTURE_FILTER_EN.
// Ports:
//   i_clk           in   system clock
//   i_reset         in   synchronous active-high reset
//   i_pwm           in   asynchronous PWM input
//   o_valid         out  1-cycle strobe, new result on the count/timeout outputs
//   o_high_count    out  high cycles of the last completed period
//   o_period_count  out  rise-to-rise cycles of the last completed period
//   o_timeout       out  last result was a timeout; held until next o_valid
//   o_level         out  conditioned input level
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int RESOLUTION    = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_pwm,
    output logic                                o_valid,
    output logic [meas_width(RESOLUTION)-1:0]   o_high_count,
    output logic [meas_width(RESOLUTION)-1:0]   o_period_count,
    output logic                                o_timeout,
    output logic                                o_level
);

    localparam int            MW          = meas_width(RESOLUTION);
    localparam logic [MW-1:0] TIMEOUT_CNT = MW'(timeout_count(RESOLUTION));
    // After reset the conditioning flops read 0 regardless of the pin, so a
    // low level is only trusted once it has outlasted that pipeline. This
    // keeps a pin that is high at reset release from producing a false rise.
    localparam logic [7:0]    SETTLE_CNT  = 8'(SYNC_STAGES + FILTER_CYCLES);

    logic level, rise, fall;

    pwm_input_conditioner #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef PWM_CAPTURE_FILTER_EN
        ,
        .FILTER_CYCLES(FILTER_CYCLES)
`endif
    ) u_cond (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_pwm  (i_pwm),
        .o_level(level),
        .o_rise (rise),
        .o_fall (fall)
    );

    pwm_state_e    state_q, state_d;
    logic [MW-1:0] period_q, period_d;
    logic [MW-1:0] high_q, high_d;
    logic [7:0]    settle_q, settle_d;
    logic          valid_q, valid_d;
    logic [MW-1:0] hout_q, hout_d;
    logic [MW-1:0] pout_q, pout_d;
    logic          tout_q, tout_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_ARM;
            period_q <= '0;
            high_q   <= '0;
            settle_q <= '0;
            valid_q  <= 1'b0;
            hout_q   <= '0;
            pout_q   <= '0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            high_q   <= high_d;
            settle_q <= settle_d;
            valid_q  <= valid_d;
            hout_q   <= hout_d;
            pout_q   <= pout_d;
            tout_q   <= tout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        high_d   = high_q;
        settle_d = settle_q;
        valid_d  = 1'b0;
        hout_d   = hout_q;
        pout_d   = pout_q;
        tout_d   = tout_q;

        unique case (state_q)
            ST_ARM: begin
                if (level) begin
                    settle_d = '0;
                end else if (settle_q == SETTLE_CNT) begin
                    settle_d = '0;
                    state_d  = ST_WAIT;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (rise) begin
                    period_d = MW'(1);
                    high_d   = MW'(1);
                    state_d  = ST_HIGH;
                end
            end
            ST_HIGH, ST_LOW: begin
                // A rise only ever occurs in LOW; it beats the timeout check.
                if (rise) begin
                    valid_d  = 1'b1;
                    pout_d   = period_q;
                    hout_d   = high_q;
                    tout_d   = 1'b0;
                    period_d = MW'(1);
                    high_d   = MW'(1);
                    state_d  = ST_HIGH;
                end else if (period_q == TIMEOUT_CNT) begin
                    // Checked before incrementing, so counters never wrap.
                    // Leaving HIGH/LOW guarantees a single timeout result.
                    valid_d  = 1'b1;
                    pout_d   = '1;
                    hout_d   = level ? '1 : high_q;
                    tout_d   = 1'b1;
                    period_d = '0;
                    high_d   = '0;
                    settle_d = '0;
                    state_d  = level ? ST_ARM : ST_WAIT;
                end else if (state_q == ST_HIGH) begin
                    period_d = period_q + MW'(1);
                    if (fall) begin
                        state_d = ST_LOW;
                    end else begin
                        high_d = high_q + MW'(1);
                    end
                end else begin
                    period_d = period_q + MW'(1);
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    assign o_valid        = valid_q;
    assign o_high_count   = hout_q;
    assign o_period_count = pout_q;
    assign o_timeout      = tout_q;
    assign o_level        = level;

endmodule
